// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM device model: pin-command and
// row-state encodings, data/strobe widths and the pin-level command decoder.
package dram_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_ACTIVATE  = 3'd1,
        CMD_PRECHARGE = 3'd2,
        CMD_READ      = 3'd3,
        CMD_WRITE     = 3'd4,
        CMD_ILLEGAL   = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACT_WAIT = 2'd1,
        ST_ROW_OPEN = 2'd2,
        ST_PRE_WAIT = 2'd3
    } state_e;

    // RASn=0 shares WEn with PRECHARGE, so only all-ones or all-zeros are meaningful there
    function automatic cmd_e decode_cmd(input logic csn, input logic rasn, input logic casn,
                                        input logic [STRB_W-1:0] wen);
        cmd_e c;
        c = CMD_NOP;
        if (csn) begin
            c = CMD_NOP;
        end else if (!rasn && !casn) begin
            c = CMD_ILLEGAL;
        end else if (!rasn) begin
            if (wen == {STRB_W{1'b1}}) begin
                c = CMD_ACTIVATE;
            end else if (wen == {STRB_W{1'b0}}) begin
                c = CMD_PRECHARGE;
            end else begin
                c = CMD_ILLEGAL;
            end
        end else if (!casn) begin
            c = (wen == {STRB_W{1'b1}}) ? CMD_READ : CMD_WRITE;
        end else begin
            c = CMD_NOP;
        end
        return c;
    endfunction

endpackage

// File: rtl/dram_array.sv
// Byte-enabled storage array: synchronous write, combinational read so a READ
// captures the word present at its own command edge. Contents are never reset.
module dram_array
    import dram_pkg::*;
#(
    parameter int ADDR_BITS = 21
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [STRB_W-1:0]    i_be,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_W-1:0]    i_wdata,
    output logic [DATA_W-1:0]    o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_BITS)-1];

    // Lane-masked write commit
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dram_device.sv
// Pin-level DRAM device model: command decode, single open row, tRCD/tRP timer,
// CL-deep read pipeline. Define DRAM_TIMING_CHECK_EN to flag and report violations.
module dram_device
    import dram_pkg::*;
#(
    parameter int ROW_BITS = 11,
    parameter int COL_BITS = 10,
    parameter int T_RCD    = 2,
    parameter int T_RP     = 2,
    parameter int CL       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DRAM_CSn,
    input  logic        DRAM_RASn,
    input  logic        DRAM_CASn,
    input  logic [3:0]  DRAM_WEn,
    input  logic [10:0] DRAM_A,
    input  logic [31:0] DRAM_D,
    output logic [31:0] DRAM_Q,
    output logic        DRAM_valid,
    output logic        DRAM_err
);

    localparam int ADDR_BITS = ROW_BITS + COL_BITS;

    cmd_e                  w_cmd;
    state_e                r_state;
    state_e                w_state_eff;
    state_e                w_state_nxt;
    logic [7:0]            r_timer;
    logic [7:0]            w_timer_nxt;
    logic [ROW_BITS-1:0]   r_row;
    logic                  w_act_fire;
    logic                  w_rd_fire;
    logic                  w_wr_fire;
    logic                  w_viol;
    logic [ADDR_BITS-1:0]  w_addr;
    logic [DATA_W-1:0]     w_rdata;
    logic [CL-1:0]         r_pipe_v;
    logic [DATA_W-1:0]     r_pipe_d [CL];
    logic [DATA_W-1:0]     r_q;
    logic                  r_valid;

    assign w_cmd  = decode_cmd(DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn);
    assign w_addr = {r_row, DRAM_A[COL_BITS-1:0]};

    dram_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_wr_fire),
        .i_be    (~DRAM_WEn),
        .i_addr  (w_addr),
        .i_wdata (DRAM_D),
        .o_rdata (w_rdata)
    );

    // Next-state and command acceptance. A wait state whose timer has reached
    // zero behaves as the state it is about to enter, which puts the earliest
    // legal command exactly T_RCD / T_RP edges after ACTIVATE / PRECHARGE.
    always_comb begin
        w_state_eff = r_state;
        w_timer_nxt = r_timer;
        w_act_fire  = 1'b0;
        w_rd_fire   = 1'b0;
        w_wr_fire   = 1'b0;
        w_viol      = 1'b0;
        case (r_state)
            ST_ACT_WAIT: begin
                if (r_timer == 8'd0) begin
                    w_state_eff = ST_ROW_OPEN;
                end else begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end
            ST_PRE_WAIT: begin
                if (r_timer == 8'd0) begin
                    w_state_eff = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end
            default: w_state_eff = r_state;
        endcase
        w_state_nxt = w_state_eff;
        case (w_cmd)
            CMD_ACTIVATE: begin
                if (w_state_eff == ST_IDLE) begin
                    w_state_nxt = ST_ACT_WAIT;
                    w_timer_nxt = 8'(T_RCD - 1);
                    w_act_fire  = 1'b1;
                end else begin
                    w_viol = 1'b1;
                end
            end
            CMD_PRECHARGE: begin
                if (w_state_eff == ST_ROW_OPEN || w_state_eff == ST_ACT_WAIT) begin
                    w_state_nxt = ST_PRE_WAIT;
                    w_timer_nxt = 8'(T_RP - 1);
                end else begin
                    w_viol = 1'b1;
                end
            end
            CMD_READ: begin
                if (w_state_eff == ST_ROW_OPEN) begin
                    w_rd_fire = 1'b1;
                end else begin
                    w_viol = 1'b1;
                end
            end
            CMD_WRITE: begin
                if (w_state_eff == ST_ROW_OPEN) begin
                    w_wr_fire = 1'b1;
                end else begin
                    w_viol = 1'b1;
                end
            end
            CMD_ILLEGAL: w_viol = 1'b1;
            default:     w_viol = 1'b0;
        endcase
    end

    // Row state, timer and open-row address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_timer <= 8'd0;
            r_row   <= {ROW_BITS{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            if (w_act_fire) begin
                r_row <= DRAM_A[ROW_BITS-1:0];
            end
        end
    end

    // Read pipeline: stage 0 loads at the READ edge, output registers at edge +CL
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe_v <= {CL{1'b0}};
            for (int i = 0; i < CL; i++) begin
                r_pipe_d[i] <= {DATA_W{1'b0}};
            end
            r_q     <= {DATA_W{1'b0}};
            r_valid <= 1'b0;
        end else begin
            r_pipe_v[0] <= w_rd_fire;
            if (w_rd_fire) begin
                r_pipe_d[0] <= w_rdata;
            end
            for (int i = 1; i < CL; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_d[i] <= r_pipe_d[i-1];
            end
            r_valid <= r_pipe_v[CL-1];
            if (r_pipe_v[CL-1]) begin
                r_q <= r_pipe_d[CL-1];
            end
        end
    end

    assign DRAM_Q     = r_q;
    assign DRAM_valid = r_valid;

`ifdef DRAM_TIMING_CHECK_EN
    logic r_err;

    // Sticky violation flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_viol) begin
            r_err <= 1'b1;
        end
    end

    // Simulation report of each rejected command
    always_ff @(posedge clk) begin
        if (rst && w_viol) begin
            $error("dram_device: command %s rejected in state %s (timer %0d)",
                   w_cmd.name(), w_state_eff.name(), r_timer);
        end
    end

    assign DRAM_err = r_err;
`else
    logic w_unused_viol;
    assign w_unused_viol = w_viol;
    assign DRAM_err      = 1'b0;
`endif

endmodule

// File: tb/tb_dram_device.sv
// Self-checking bench for dram_device: directed vector table, reset corner case,
// and randomized command traffic against a timestamp-based reference model.
module tb_dram_device;

    localparam int T_RCD = 2;
    localparam int T_RP  = 2;
    localparam int CL    = 3;
`ifdef DRAM_TIMING_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    localparam int K_NOP = 0, K_ACT = 1, K_PRE = 2, K_RD = 3, K_WR = 4, K_ILL = 5, K_DES = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        DRAM_CSn = 1'b1;
    logic        DRAM_RASn = 1'b1;
    logic        DRAM_CASn = 1'b1;
    logic [3:0]  DRAM_WEn = 4'hF;
    logic [10:0] DRAM_A = 11'd0;
    logic [31:0] DRAM_D = 32'd0;
    logic [31:0] DRAM_Q;
    logic        DRAM_valid;
    logic        DRAM_err;

    dram_device #(
        .ROW_BITS (11), .COL_BITS (10), .T_RCD (T_RCD), .T_RP (T_RP), .CL (CL)
    ) dut (
        .clk (clk), .rst (rst),
        .DRAM_CSn (DRAM_CSn), .DRAM_RASn (DRAM_RASn), .DRAM_CASn (DRAM_CASn),
        .DRAM_WEn (DRAM_WEn), .DRAM_A (DRAM_A), .DRAM_D (DRAM_D),
        .DRAM_Q (DRAM_Q), .DRAM_valid (DRAM_valid), .DRAM_err (DRAM_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model: open-row flag plus the edge numbers at which the next
    // column / activate command becomes legal; reads wait in a due-edge queue.
    typedef struct { int due; logic [31:0] data; } rd_t;
    bit          m_open;
    int          m_row;
    int          m_act_ready;
    int          m_pre_ready;
    logic [31:0] mem [int];
    rd_t         rdq [$];
    logic [31:0] m_q;
    logic        m_valid;
    logic        m_err;

    typedef struct {
        int          k;
        logic [10:0] a;
        logic [31:0] d;
        logic [3:0]  w;
        logic        ev;
        logic [31:0] eq;
        logic        ee;
    } vec_t;
    vec_t tbl [29];

    function automatic vec_t mk(int k, logic [10:0] a, logic [31:0] d, logic [3:0] w,
                                logic ev, logic [31:0] eq, logic ee);
        vec_t v;
        v.k = k; v.a = a; v.d = d; v.w = w; v.ev = ev; v.eq = eq; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_open      = 1'b0;
        m_act_ready = 0;
        m_pre_ready = 0;
        rdq.delete();
        m_q     = 32'd0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge(input int k, input logic [10:0] a, input logic [31:0] d,
                              input logic [3:0] w);
        int          idx;
        bit          viol;
        logic [31:0] word;
        viol    = 1'b0;
        m_valid = 1'b0;
        if (rdq.size() > 0 && rdq[0].due == edge_n) begin
            m_valid = 1'b1;
            m_q     = rdq[0].data;
            void'(rdq.pop_front());
        end
        idx = m_row * 1024 + int'(a[9:0]);
        case (k)
            K_ACT: begin
                if (!m_open && edge_n >= m_pre_ready) begin
                    m_open = 1'b1; m_row = int'(a); m_act_ready = edge_n + T_RCD;
                end else viol = 1'b1;
            end
            K_PRE: begin
                if (m_open) begin
                    m_open = 1'b0; m_pre_ready = edge_n + T_RP;
                end else viol = 1'b1;
            end
            K_RD: begin
                if (m_open && edge_n >= m_act_ready) rdq.push_back('{edge_n + CL, mem[idx]});
                else viol = 1'b1;
            end
            K_WR: begin
                if (m_open && edge_n >= m_act_ready) begin
                    word = mem.exists(idx) ? mem[idx] : 32'd0;
                    for (int b = 0; b < 4; b++) if (!w[b]) word[8*b +: 8] = d[8*b +: 8];
                    mem[idx] = word;
                end else viol = 1'b1;
            end
            K_ILL:   viol = 1'b1;
            default: viol = 1'b0;
        endcase
        if (viol) m_err = m_err | ERR_ON;
    endtask

    task automatic drive(input int k, input logic [10:0] a, input logic [31:0] d,
                         input logic [3:0] w);
        DRAM_CSn = 1'b0; DRAM_A = a; DRAM_D = d; DRAM_WEn = w;
        case (k)
            K_ACT: begin DRAM_RASn = 1'b0; DRAM_CASn = 1'b1; DRAM_WEn = 4'hF; end
            K_PRE: begin DRAM_RASn = 1'b0; DRAM_CASn = 1'b1; DRAM_WEn = 4'h0; end
            K_RD:  begin DRAM_RASn = 1'b1; DRAM_CASn = 1'b0; DRAM_WEn = 4'hF; end
            K_WR:  begin DRAM_RASn = 1'b1; DRAM_CASn = 1'b0; end
            K_ILL: begin
                DRAM_RASn = 1'b0;
                DRAM_CASn = (w == 4'hF || w == 4'h0) ? 1'b0 : 1'b1;
            end
            K_DES: begin DRAM_CSn = 1'b1; DRAM_RASn = a[0]; DRAM_CASn = a[1]; end
            default: begin DRAM_RASn = 1'b1; DRAM_CASn = 1'b1; end
        endcase
    endtask

    task automatic step(input int k, input logic [10:0] a, input logic [31:0] d,
                        input logic [3:0] w);
        drive(k, a, d, w);
        @(posedge clk);
        model_edge(k, a, d, w);
        #1;
        check("valid", {31'd0, DRAM_valid}, {31'd0, m_valid});
        check("q", DRAM_Q, m_q);
        check("err", {31'd0, DRAM_err}, {31'd0, m_err});
        edge_n++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        DRAM_CSn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_valid", {31'd0, DRAM_valid}, 32'd0);
        check("rst_q", DRAM_Q, 32'd0);
        check("rst_err", {31'd0, DRAM_err}, 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        logic [10:0] ra;
        logic [3:0]  rw;
        int          r;
        int          k;

        tbl[0]  = mk(K_ACT, 11'h005, 32'h0,        4'hF, 1'b0, 32'h0,        1'b0);
        tbl[1]  = mk(K_NOP, 11'h000, 32'h0,        4'hF, 1'b0, 32'h0,        1'b0);
        tbl[2]  = mk(K_WR,  11'h010, 32'hDEADBEEF, 4'h0, 1'b0, 32'h0,        1'b0);
        tbl[3]  = mk(K_RD,  11'h010, 32'h0,        4'hF, 1'b0, 32'h0,        1'b0);
        tbl[4]  = mk(K_NOP, 11'h000, 32'h0,        4'hF, 1'b0, 32'h0,        1'b0);
        tbl[5]  = mk(K_NOP, 11'h000, 32'h0,        4'hF, 1'b0, 32'h0,        1'b0);
        tbl[6]  = mk(K_NOP, 11'h000, 32'h0,        4'hF, 1'b1, 32'hDEADBEEF, 1'b0);
        tbl[7]  = mk(K_WR,  11'h010, 32'h11223344, 4'hC, 1'b0, 32'hDEADBEEF, 1'b0);
        tbl[8]  = mk(K_RD,  11'h010, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF, 1'b0);
        tbl[9]  = mk(K_WR,  11'h000, 32'h000000A0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        tbl[10] = mk(K_WR,  11'h001, 32'h000000A1, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        tbl[11] = mk(K_WR,  11'h002, 32'h000000A2, 4'h0, 1'b1, 32'hDEAD3344, 1'b0);
        tbl[12] = mk(K_RD,  11'h000, 32'h0,        4'hF, 1'b0, 32'hDEAD3344, 1'b0);
        tbl[13] = mk(K_RD,  11'h001, 32'h0,        4'hF, 1'b0, 32'hDEAD3344, 1'b0);
        tbl[14] = mk(K_RD,  11'h002, 32'h0,        4'hF, 1'b0, 32'hDEAD3344, 1'b0);
        tbl[15] = mk(K_NOP, 11'h000, 32'h0,        4'hF, 1'b1, 32'h000000A0, 1'b0);
        tbl[16] = mk(K_NOP, 11'h000, 32'h0,        4'hF, 1'b1, 32'h000000A1, 1'b0);
        tbl[17] = mk(K_NOP, 11'h000, 32'h0,        4'hF, 1'b1, 32'h000000A2, 1'b0);
        tbl[18] = mk(K_NOP, 11'h000, 32'h0,        4'hF, 1'b0, 32'h000000A2, 1'b0);
        tbl[19] = mk(K_PRE, 11'h000, 32'h0,        4'h0, 1'b0, 32'h000000A2, 1'b0);
        tbl[20] = mk(K_ACT, 11'h007, 32'h0,        4'hF, 1'b0, 32'h000000A2, ERR_ON);
        tbl[21] = mk(K_ACT, 11'h007, 32'h0,        4'hF, 1'b0, 32'h000000A2, ERR_ON);
        tbl[22] = mk(K_RD,  11'h003, 32'h0,        4'hF, 1'b0, 32'h000000A2, ERR_ON);
        tbl[23] = mk(K_WR,  11'h003, 32'h00000055, 4'h0, 1'b0, 32'h000000A2, ERR_ON);
        tbl[24] = mk(K_RD,  11'h403, 32'h0,        4'hF, 1'b0, 32'h000000A2, ERR_ON);
        tbl[25] = mk(K_NOP, 11'h000, 32'h0,        4'hF, 1'b0, 32'h000000A2, ERR_ON);
        tbl[26] = mk(K_NOP, 11'h000, 32'h0,        4'hF, 1'b0, 32'h000000A2, ERR_ON);
        tbl[27] = mk(K_NOP, 11'h000, 32'h0,        4'hF, 1'b1, 32'h00000055, ERR_ON);
        tbl[28] = mk(K_ILL, 11'h000, 32'h0,        4'hF, 1'b0, 32'h00000055, ERR_ON);

        do_reset();
        for (int i = 0; i < 29; i++) begin
            step(tbl[i].k, tbl[i].a, tbl[i].d, tbl[i].w);
            check($sformatf("tbl%0d_valid", i), {31'd0, DRAM_valid}, {31'd0, tbl[i].ev});
            check($sformatf("tbl%0d_q", i), DRAM_Q, tbl[i].eq);
            check($sformatf("tbl%0d_err", i), {31'd0, DRAM_err}, {31'd0, tbl[i].ee});
        end

        // Reset asserted one cycle after a READ drops it and closes the row
        step(K_RD, 11'h003, 32'h0, 4'hF);
        rst = 1'b0;
        DRAM_CSn = 1'b1;
        #1;
        check("midrst_valid", {31'd0, DRAM_valid}, 32'd0);
        check("midrst_q", DRAM_Q, 32'd0);
        check("midrst_err", {31'd0, DRAM_err}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < CL + 2; i++) step(K_NOP, 11'h0, 32'h0, 4'hF);
        step(K_RD, 11'h003, 32'h0, 4'hF);
        for (int i = 0; i < CL + 1; i++) step(K_NOP, 11'h0, 32'h0, 4'hF);
        step(K_ACT, 11'h007, 32'h0, 4'hF);
        step(K_NOP, 11'h0, 32'h0, 4'hF);
        step(K_RD, 11'h003, 32'h0, 4'hF);
        for (int i = 0; i < CL + 1; i++) step(K_NOP, 11'h0, 32'h0, 4'hF);

        // Preload rows 0..3, cols 0..7 so random reads always hit known data
        do_reset();
        for (int row = 0; row < 4; row++) begin
            step(K_ACT, 11'(row), 32'h0, 4'hF);
            step(K_NOP, 11'h0, 32'h0, 4'hF);
            for (int c = 0; c < 8; c++) step(K_WR, 11'(c), $urandom, 4'h0);
            step(K_PRE, 11'h0, 32'h0, 4'h0);
            step(K_NOP, 11'h0, 32'h0, 4'hF);
        end

        for (int n = 0; n < 800; n++) begin
            r  = $urandom_range(0, 99);
            rw = 4'($urandom_range(0, 15));
            if (r < 15)      begin k = K_NOP; ra = 11'($urandom); end
            else if (r < 27) begin k = K_ACT; ra = 11'($urandom_range(0, 3)); end
            else if (r < 37) begin k = K_PRE; ra = 11'($urandom); end
            else if (r < 62) begin k = K_RD;  ra = {1'($urandom), 7'd0, 3'($urandom)}; end
            else if (r < 87) begin
                k  = K_WR;
                ra = {1'($urandom), 7'd0, 3'($urandom)};
                rw = 4'($urandom_range(0, 14));
            end
            else if (r < 92) begin k = K_ILL; ra = 11'($urandom); end
            else             begin k = K_DES; ra = 11'($urandom); end
            step(k, ra, $urandom, rw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
